ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter for the calculator's PS/2 port. It sends command bytes (for example 0xED set-LEDs, 0xFF reset) to the keyboard.
- It performs the full host request-to-send sequence on the shared open-drain clock/data lines, then checks the device acknowledge.
- It sits beside the existing PS/2 keyboard receiver in xtop. It asserts `busy` so the receiver ignores line activity during a host transmission.

---
 rtl/ps2_host_tx.sv | 197 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, issues request-to-send, shifts the frame out on
// device-generated clock falls and checks the device acknowledge.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bit_idx, bit_idx_n;
  logic [9:0]       shreg, shreg_n;
  logic             clk_oe_n, data_oe_n, done_n, err_n;

  logic clk_meta, clk_s, clk_s_d;
  logic data_meta, data_s;
  logic fall;

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign fall     = clk_s_d & ~clk_s;

  // Two-flop synchronizers for the asynchronous bus pins plus a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_s     <= 1'b1;
      clk_s_d   <= 1'b1;
      data_meta <= 1'b1;
      data_s    <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_i;
      clk_s     <= clk_meta;
      clk_s_d   <= clk_s;
      data_meta <= ps2_data_i;
      data_s    <= data_meta;
    end
  end

  // State, datapath and registered line-driver/pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      err         <= err_n;
    end
  end

  // Next-state logic; a pending done/err pulse always returns to IDLE first, and timeout beats a fall
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    err_n     = 1'b0;

    if (done || err) begin
      state_n   = IDLE;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      cnt_n     = '0;
    end else begin
      case (state)
        IDLE: begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          if (tx_valid) begin
            shreg_n   = {1'b1, ~^tx_data, tx_data};
            cnt_n     = '0;
            bit_idx_n = '0;
            clk_oe_n  = 1'b1;
            state_n   = INHIBIT;
          end
        end

        INHIBIT: begin
          clk_oe_n  = 1'b1;
          data_oe_n = 1'b0;
          if (cnt == INHIBIT_LAST) begin
            cnt_n     = '0;
            data_oe_n = 1'b1;
            state_n   = RTS;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end

        RTS: begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = SEND;
        end

        SEND: begin
          if (cnt == TIMEOUT_LAST) begin
            err_n     = 1'b1;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
          end else begin
            cnt_n = cnt + CNT_ONE;
            if (fall) begin
              data_oe_n = ~shreg[bit_idx];
              bit_idx_n = bit_idx + 4'd1;
              if (bit_idx == 4'd9) begin
                data_oe_n = 1'b0;
                state_n   = ACK;
              end
            end
          end
        end

        ACK: begin
          if (cnt == TIMEOUT_LAST) begin
            err_n     = 1'b1;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
          end else begin
            cnt_n = cnt + CNT_ONE;
            if (fall) begin
              if (data_s) begin
                err_n = 1'b1;
              end else begin
                state_n = WAIT_IDLE;
              end
            end
          end
        end

        WAIT_IDLE: begin
          if (cnt == TIMEOUT_LAST) begin
            err_n     = 1'b1;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
          end else begin
            cnt_n = cnt + CNT_ONE;
            if (clk_s && data_s) begin
              done_n = 1'b1;
            end
          end
        end

        default: begin
          state_n   = IDLE;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives command frames into ps2_host_tx against a PS/2 keyboard model
// that clocks the bus, decodes the host frame and optionally acknowledges.
module tb_ps2_host_tx;

  localparam int INHIBIT    = 5000;
  localparam int TIMEOUT    = 2000;
  localparam int DEV_HALF   = 25;
  localparam int WAIT_LIMIT = 8000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, err;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  int n_compared   = 0;
  int n_mismatched = 0;

  int cycle           = 0;
  int done_total      = 0;
  int err_total       = 0;
  int both_total      = 0;
  int inh_total       = 0;
  int rts_total       = 0;
  int release_cycle   = 0;
  int err_cycle       = 0;
  int pulse_idle_viol = 0;
  int pulse_busy_viol = 0;
  int clk_oe_viol     = 0;
  logic prev_clk_oe, prev_pulse, prev_err;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk_i(ps2_clk_line),
    .ps2_data_i(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done),
    .err(err)
  );

  // System clock
  always #5 clk = ~clk;

  // Bus monitor sampling on the falling edge: pulse counts, inhibit/RTS lengths, ordering rules
  always @(negedge clk) begin
    cycle       <= cycle + 1;
    prev_clk_oe <= ps2_clk_oe;
    prev_pulse  <= done | err;
    prev_err    <= err;
    if (done === 1'b1) done_total <= done_total + 1;
    if (err === 1'b1) err_total <= err_total + 1;
    if (done === 1'b1 && err === 1'b1) both_total <= both_total + 1;
    if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) inh_total <= inh_total + 1;
    if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1) rts_total <= rts_total + 1;
    if (prev_clk_oe === 1'b1 && ps2_clk_oe === 1'b0) release_cycle <= cycle;
    if (err === 1'b1 && prev_err !== 1'b1) err_cycle <= cycle;
    if (prev_pulse === 1'b1 && tx_ready !== 1'b1) pulse_idle_viol <= pulse_idle_viol + 1;
    if ((done === 1'b1 || err === 1'b1) && busy !== 1'b1) pulse_busy_viol <= pulse_busy_viol + 1;
    if (ps2_clk_oe === 1'b1 && busy !== 1'b1) clk_oe_viol <= clk_oe_viol + 1;
  end

  // Watchdog so the run can never hang
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: observed still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {31'b0, observed}, {31'b0, expected});
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference frame as the keyboard sees it: start 0, data LSB first, odd parity, stop 1
  function automatic logic [10:0] expectedFrame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic applyStimulus(input logic [7:0] d, input bit hold);
    int guard;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    guard    = 0;
    while (tx_ready !== 1'b1 && guard < WAIT_LIMIT) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    checkBit($sformatf("accept_%02h_busy", d), busy, 1'b1);
  endtask

  task automatic waitReady(input string tag);
    int guard;
    guard = 0;
    while (tx_ready !== 1'b1 && guard < WAIT_LIMIT) begin
      @(negedge clk);
      guard++;
    end
    checkBit({tag, "_ready"}, tx_ready, 1'b1);
    waitCycles(2);
  endtask

  // Keyboard model: waits for request-to-send, clocks n_clocks bits sampling on the rising edge,
  // and on the 11th clock pulls data low when give_ack is set
  task automatic deviceFrame(input int n_clocks, input bit give_ack, output logic [10:0] seen, output bit ok);
    int guard;
    seen  = '0;
    ok    = 1'b0;
    guard = 0;
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && guard < INHIBIT + 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= INHIBIT + 200) return;
    ok = 1'b1;
    waitCycles(10);
    seen[0] = ps2_data_line;
    for (int k = 1; k <= 10 && k <= n_clocks; k++) begin
      dev_clk_low = 1'b1;
      waitCycles(DEV_HALF);
      dev_clk_low = 1'b0;
      seen[k] = ps2_data_line;
      waitCycles(DEV_HALF);
    end
    if (n_clocks >= 11) begin
      if (give_ack) dev_data_low = 1'b1;
      waitCycles(5);
      dev_clk_low = 1'b1;
      waitCycles(DEV_HALF);
      dev_clk_low = 1'b0;
      waitCycles(5);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic checkFrame(input string tag, input logic [10:0] seen, input logic [7:0] d);
    logic [10:0] exp;
    exp = expectedFrame(d);
    checkBit({tag, "_start"}, seen[0], exp[0]);
    checkOutput({tag, "_data"}, {24'b0, seen[8:1]}, {24'b0, exp[8:1]});
    checkBit({tag, "_parity"}, seen[9], exp[9]);
    checkBit({tag, "_stop"}, seen[10], exp[10]);
  endtask

  task automatic runFrame(input string tag, input logic [7:0] d, input bit give_ack);
    logic [10:0] seen;
    bit ok;
    int b_done, b_err, b_inh, b_rts;
    b_done = done_total;
    b_err  = err_total;
    b_inh  = inh_total;
    b_rts  = rts_total;
    applyStimulus(d, 1'b0);
    deviceFrame(11, give_ack, seen, ok);
    checkBit({tag, "_rts_seen"}, ok, 1'b1);
    waitReady(tag);
    checkFrame(tag, seen, d);
    checkOutput({tag, "_inhibit_len"}, inh_total - b_inh, INHIBIT);
    checkOutput({tag, "_rts_len"}, rts_total - b_rts, 32'd1);
    checkOutput({tag, "_done_count"}, done_total - b_done, give_ack ? 32'd1 : 32'd0);
    checkOutput({tag, "_err_count"}, err_total - b_err, give_ack ? 32'd0 : 32'd1);
    checkOutput({tag, "_lines_released"}, {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  // Directed sequence followed by a couple of random command bytes
  initial begin
    logic [10:0] seen;
    logic [10:0] exp;
    bit ok;
    int guard;
    int b_done, b_err, b_inh;
    logic [7:0] rnd;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    waitCycles(5);
    checkBit("reset_tx_ready", tx_ready, 1'b1);
    checkBit("reset_busy", busy, 1'b0);
    checkBit("reset_clk_oe", ps2_clk_oe, 1'b0);
    checkBit("reset_data_oe", ps2_data_oe, 1'b0);
    checkBit("reset_done", done, 1'b0);
    checkBit("reset_err", err, 1'b0);
    rst = 1'b0;
    waitCycles(3);

    $display("[TB] frame 0xED");
    runFrame("ed", 8'hED, 1'b1);
    $display("[TB] frame 0xF4");
    runFrame("f4", 8'hF4, 1'b1);

    $display("[TB] back-to-back 0x00 / 0xFF with tx_valid held");
    b_done = done_total;
    b_err  = err_total;
    b_inh  = inh_total;
    applyStimulus(8'h00, 1'b1);
    tx_data = 8'hFF;
    deviceFrame(11, 1'b1, seen, ok);
    checkBit("b2b0_rts_seen", ok, 1'b1);
    checkFrame("b2b0", seen, 8'h00);
    checkOutput("b2b0_inhibit_len", inh_total - b_inh, INHIBIT);
    guard = 0;
    while (done !== 1'b1 && guard < WAIT_LIMIT) begin
      @(negedge clk);
      guard++;
    end
    checkBit("b2b0_done", done, 1'b1);
    @(negedge clk);
    checkBit("b2b_idle_gap", tx_ready, 1'b1);
    @(negedge clk);
    checkBit("b2b1_accepted", busy, 1'b1);
    tx_valid = 1'b0;
    deviceFrame(11, 1'b1, seen, ok);
    checkBit("b2b1_rts_seen", ok, 1'b1);
    waitReady("b2b1");
    checkFrame("b2b1", seen, 8'hFF);
    checkOutput("b2b_done_count", done_total - b_done, 32'd2);
    checkOutput("b2b_err_count", err_total - b_err, 32'd0);
    checkOutput("b2b_inhibit_len", inh_total - b_inh, 2 * INHIBIT);

    $display("[TB] no acknowledge");
    runFrame("noack", 8'h5A, 1'b0);

    $display("[TB] timeout, device never clocks");
    b_done = done_total;
    b_err  = err_total;
    applyStimulus(8'hA5, 1'b0);
    deviceFrame(0, 1'b0, seen, ok);
    checkBit("timeout_rts_seen", ok, 1'b1);
    waitReady("timeout");
    checkOutput("timeout_err_count", err_total - b_err, 32'd1);
    checkOutput("timeout_done_count", done_total - b_done, 32'd0);
    checkOutput("timeout_latency", err_cycle - release_cycle, TIMEOUT);
    checkOutput("timeout_lines_released", {30'b0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    runFrame("ed_after_timeout", 8'hED, 1'b1);

    $display("[TB] reset during SEND");
    b_done = done_total;
    b_err  = err_total;
    exp    = expectedFrame(8'h35);
    applyStimulus(8'h35, 1'b0);
    deviceFrame(4, 1'b0, seen, ok);
    checkBit("rst_rts_seen", ok, 1'b1);
    checkOutput("rst_first_bits", {28'b0, seen[4:1]}, {28'b0, exp[4:1]});
    checkBit("rst_busy_before", busy, 1'b1);
    checkBit("rst_data_oe_before", ps2_data_oe, ~exp[4]);
    rst = 1'b1;
    @(negedge clk);
    checkBit("rst_clk_oe", ps2_clk_oe, 1'b0);
    checkBit("rst_data_oe", ps2_data_oe, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_tx_ready", tx_ready, 1'b1);
    checkBit("rst_done", done, 1'b0);
    checkBit("rst_err", err, 1'b0);
    rst = 1'b0;
    waitCycles(5);
    checkOutput("rst_no_pulses", (done_total - b_done) + (err_total - b_err), 32'd0);

    for (int i = 0; i < 2; i++) begin
      rnd = 8'($urandom);
      $display("[TB] random frame 0x%02h", rnd);
      runFrame($sformatf("rand%0d_%02h", i, rnd), rnd, 1'b1);
    end

    checkOutput("done_err_together", both_total, 32'd0);
    checkOutput("pulse_then_idle", pulse_idle_viol, 32'd0);
    checkOutput("pulse_while_busy", pulse_busy_viol, 32'd0);
    checkOutput("clk_oe_only_when_busy", clk_oe_viol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
